// File: rtl/cic_region_sequencer.sv
// Console reset / CIC release / region retry sequencer for the SNES test board.
// Tries one region, toggles it on CIC failure up to MAX_RETRY times, then locks out.
module cic_region_sequencer #(
    parameter int unsigned RESET_HOLD     = 1024,
    parameter int unsigned CIC_SETTLE     = 32767,
    parameter int unsigned MAX_RETRY      = 3,
    parameter bit          DEFAULT_REGION = 1'b0
) (
    input  logic       CLK_i,
    input  logic       RST_i,
    input  logic       RESET_BTN_i,
    input  logic       IGR_RST_REQ_i,
    input  logic       IGR_REGION_REQ_i,
    input  logic       CIC_FAIL_i,
    output logic       SYS_RESET_o,
    output logic       CIC_EN_o,
    output logic       REGION_o,
    output logic       FAIL_o,
    output logic [1:0] RETRY_o
);

    localparam int unsigned CNT_MAX = (RESET_HOLD > CIC_SETTLE) ? RESET_HOLD : CIC_SETTLE;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CW-1:0] HOLD_LOAD   = CW'(RESET_HOLD - 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(CIC_SETTLE - 1);
    localparam logic [RW-1:0] RETRY_LIM   = RW'(MAX_RETRY);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_SETTLE,
        ST_RUN,
        ST_LOCKOUT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic            region_q, region_d;
    logic [1:0]      retry_sat;

    assign REGION_o = region_q;

    // Next state: region request beats plain restarts, which beat CIC failure.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        region_d = region_q;
        retry_d  = retry_q;

        if (IGR_REGION_REQ_i) begin
            state_d  = ST_HOLD;
            cnt_d    = HOLD_LOAD;
            region_d = ~region_q;
            retry_d  = '0;
        end else if (RESET_BTN_i || IGR_RST_REQ_i) begin
            state_d  = ST_HOLD;
            cnt_d    = HOLD_LOAD;
            retry_d  = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == '0) begin
                        state_d = ST_SETTLE;
                        cnt_d   = SETTLE_LOAD;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_RUN: begin
                    if (CIC_FAIL_i) begin
                        if (retry_q < RETRY_LIM) begin
                            state_d  = ST_HOLD;
                            cnt_d    = HOLD_LOAD;
                            region_d = ~region_q;
                            retry_d  = retry_q + RW'(1);
                        end else begin
                            state_d = ST_LOCKOUT;
                        end
                    end
                end
                ST_LOCKOUT: ;
                default: begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            endcase
        end

        retry_sat = (32'(retry_d) > 32'd3) ? 2'd3 : 2'(retry_d);
    end

    // State and registered output decodes.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            state_q     <= ST_HOLD;
            cnt_q       <= HOLD_LOAD;
            region_q    <= DEFAULT_REGION;
            retry_q     <= '0;
            SYS_RESET_o <= 1'b1;
            CIC_EN_o    <= 1'b0;
            FAIL_o      <= 1'b0;
            RETRY_o     <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            region_q    <= region_d;
            retry_q     <= retry_d;
            SYS_RESET_o <= (state_d != ST_RUN);
            CIC_EN_o    <= (state_d == ST_RUN);
            FAIL_o      <= (state_d == ST_LOCKOUT);
            RETRY_o     <= retry_sat;
        end
    end

endmodule

// File: tb/tb_cic_region_sequencer.sv
// Directed bench for cic_region_sequencer: a MAX_RETRY=2 instance and a MAX_RETRY=0 instance.
module tb_cic_region_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, btn, igr_rst, igr_reg, fail;
    logic       sys_reset, cic_en, region, fail_led;
    logic [1:0] retry;

    logic       rst_z, btn_z, igr_rst_z, igr_reg_z, fail_z;
    logic       sys_reset_z, cic_en_z, region_z, fail_led_z;
    logic [1:0] retry_z;

    int errors = 0;
    int checks = 0;

    cic_region_sequencer #(
        .RESET_HOLD(4), .CIC_SETTLE(8), .MAX_RETRY(2), .DEFAULT_REGION(1'b0)
    ) u_dut (
        .CLK_i(clk), .RST_i(rst), .RESET_BTN_i(btn), .IGR_RST_REQ_i(igr_rst),
        .IGR_REGION_REQ_i(igr_reg), .CIC_FAIL_i(fail), .SYS_RESET_o(sys_reset),
        .CIC_EN_o(cic_en), .REGION_o(region), .FAIL_o(fail_led), .RETRY_o(retry)
    );

    cic_region_sequencer #(
        .RESET_HOLD(4), .CIC_SETTLE(8), .MAX_RETRY(0), .DEFAULT_REGION(1'b0)
    ) u_dut_z (
        .CLK_i(clk), .RST_i(rst_z), .RESET_BTN_i(btn_z), .IGR_RST_REQ_i(igr_rst_z),
        .IGR_REGION_REQ_i(igr_reg_z), .CIC_FAIL_i(fail_z), .SYS_RESET_o(sys_reset_z),
        .CIC_EN_o(cic_en_z), .REGION_o(region_z), .FAIL_o(fail_led_z), .RETRY_o(retry_z)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycles until SYS_RESET drops on the selected instance, bounded at 200.
    task automatic wait_run(input bit sel_z, output int n);
        n = 0;
        while (((sel_z ? sys_reset_z : sys_reset) == 1'b1) && n < 200) begin
            step();
            n++;
        end
    endtask

    int n;
    int low_cnt;

    initial begin
        rst = 1; btn = 0; igr_rst = 0; igr_reg = 0; fail = 0;
        rst_z = 1; btn_z = 0; igr_rst_z = 0; igr_reg_z = 0; fail_z = 0;
        step(); step();
        rst = 0;

        check("rst_sysreset", 32'(sys_reset), 1);
        check("rst_cic_en",   32'(cic_en),    0);
        check("rst_region",   32'(region),    0);
        check("rst_fail",     32'(fail_led),  0);
        check("rst_retry",    32'(retry),     0);

        wait_run(1'b0, n);
        check("reset_to_run", n, 12);
        check("run_cic_en",   32'(cic_en), 1);
        check("run_region",   32'(region), 0);
        check("run_retry",    32'(retry),  0);

        // First failure: toggle to PAL, retry 1.
        fail = 1; step(); fail = 0;
        check("f1_region",    32'(region),    1);
        check("f1_retry",     32'(retry),     1);
        check("f1_cic_en",    32'(cic_en),    0);
        check("f1_sysreset",  32'(sys_reset), 1);
        wait_run(1'b0, n);
        check("f1_to_run",    n, 12);

        fail = 1; step(); fail = 0;
        check("f2_region",    32'(region), 0);
        check("f2_retry",     32'(retry),  2);
        wait_run(1'b0, n);
        check("f2_to_run",    n, 12);

        // Third failure exceeds the limit: lockout with region untouched.
        fail = 1; step();
        check("f3_fail_led",  32'(fail_led),  1);
        check("f3_retry",     32'(retry),     2);
        check("f3_region",    32'(region),    0);
        check("f3_sysreset",  32'(sys_reset), 1);
        low_cnt = 0;
        for (int i = 0; i < 110; i++) begin
            fail = i[0];
            step();
            if (sys_reset !== 1'b1 || fail_led !== 1'b1) low_cnt++;
        end
        fail = 0;
        check("lockout_held", low_cnt, 0);
        check("lockout_retry", 32'(retry), 2);

        // Combined region + reset request: one toggle, one restart.
        igr_reg = 1; igr_rst = 1; step(); igr_reg = 0; igr_rst = 0;
        check("unlock_fail_led", 32'(fail_led), 0);
        check("unlock_retry",    32'(retry),    0);
        check("unlock_region",   32'(region),   1);
        wait_run(1'b0, n);
        check("unlock_to_run",   n, 12);
        check("unlock_region2",  32'(region),   1);

        // Button held through SETTLE with CIC_FAIL high: nothing counted.
        igr_rst = 1; step(); igr_rst = 0;
        for (int i = 0; i < 6; i++) step();
        check("settle_sysreset", 32'(sys_reset), 1);
        btn = 1; fail = 1;
        for (int i = 0; i < 5; i++) step();
        check("btn_retry_hold", 32'(retry), 0);
        btn = 0; fail = 0;
        wait_run(1'b0, n);
        check("btn_to_run",   n, 12);
        check("btn_retry",    32'(retry),  0);
        check("btn_region",   32'(region), 1);

        // MAX_RETRY=0 instance.
        rst_z = 0;
        wait_run(1'b1, n);
        check("z_reset_to_run", n, 12);
        fail_z = 1; step(); fail_z = 0;
        check("z_fail_led",  32'(fail_led_z),  1);
        check("z_region",    32'(region_z),    0);
        check("z_retry",     32'(retry_z),     0);
        check("z_sysreset",  32'(sys_reset_z), 1);

        igr_reg_z = 1; step(); igr_reg_z = 0;
        check("z_req_region", 32'(region_z), 1);
        step(); step();
        rst_z = 1; step(); rst_z = 0;
        check("z_rst_region",   32'(region_z),    0);
        check("z_rst_fail",     32'(fail_led_z),  0);
        check("z_rst_sysreset", 32'(sys_reset_z), 1);
        check("z_rst_cic_en",   32'(cic_en_z),    0);
        wait_run(1'b1, n);
        check("z_rst_to_run",   n, 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cic_region_sequencer.md
# cic_region_sequencer

Sequences console reset, CIC lock release and region selection for the SNES test board. It replaces ad-hoc region toggling with an explicit retry state machine. It drives the lock module's enable and PAL/NTSC select, holds the console in reset while a region is tried, and retries the other region on CIC failure up to a limit before locking out. It also accepts reset and region-toggle requests from the in-game-reset controller.

## Interface
Parameters:
- RESET_HOLD, 1024: cycles SYS_RESET_o is held before the CIC settle phase (≥1).
- CIC_SETTLE, 32767: cycles CIC_EN_o stays low after hold, before release (≥1).
- MAX_RETRY, 3: region toggles allowed on CIC failure before lockout (≥0).
- DEFAULT_REGION, 0: REGION_o value after reset (0 = NTSC, 1 = PAL).

Ports:
- CLK_i, in, 1: master clock. All logic runs on the rising edge.
- RST_i, in, 1: synchronous, active-high reset.
- RESET_BTN_i, in, 1: console reset button, level, already synchronised to CLK_i.
- IGR_RST_REQ_i, in, 1: single-cycle pulse requesting a console reset.
- IGR_REGION_REQ_i, in, 1: single-cycle pulse requesting a region toggle plus reset.
- CIC_FAIL_i, in, 1: failure flag from the CIC lock module, level.
- SYS_RESET_o, out, 1: console reset, active high.
- CIC_EN_o, out, 1: releases the CIC lock module (its pll_locked input).
- REGION_o, out, 1: PAL/NTSC select to the CIC lock module and the REGION pin.
- FAIL_o, out, 1: lockout indicator, drives an LED.
- RETRY_o, out, 2: retries used since the last clean start, saturating at 3.

## Operation
- States: HOLD, SETTLE, RUN, LOCKOUT. The state is registered, and all outputs are registered decodes of it.
- Reset (RST_i=1): state HOLD, counter loaded with RESET_HOLD-1, SYS_RESET_o=1, CIC_EN_o=0, REGION_o=DEFAULT_REGION, FAIL_o=0, retry=0.
- HOLD: SYS_RESET_o=1, CIC_EN_o=0. The counter decrements, and at 0 the block goes to SETTLE with the counter loaded to CIC_SETTLE-1.
- SETTLE: SYS_RESET_o=1, CIC_EN_o=0. The counter decrements, and at 0 the block goes to RUN.
- RUN: SYS_RESET_o=0, CIC_EN_o=1. If CIC_FAIL_i=1 is sampled:
  - when retry<MAX_RETRY: REGION_o toggles, retry increments, and the block goes to HOLD (counter reloaded);
  - otherwise: the block goes to LOCKOUT.
- LOCKOUT: SYS_RESET_o=1, CIC_EN_o=0, FAIL_o=1. The block stays here until a restart event. CIC_FAIL_i is ignored.
- Restart events, valid in any state:
  - RESET_BTN_i=1 or IGR_RST_REQ_i=1: go to HOLD, retry=0, FAIL_o=0, REGION_o unchanged.
  - IGR_REGION_REQ_i=1: same as above, and REGION_o also toggles.
  - While RESET_BTN_i is held high, the block remains in HOLD with the counter reloaded every cycle. The hold count starts on the first cycle after release.
- Priority in one cycle: RST_i, then IGR_REGION_REQ_i, then RESET_BTN_i/IGR_RST_REQ_i, then CIC_FAIL_i.
  - IGR_REGION_REQ_i together with another restart produces a single toggle and a single restart.
  - CIC_FAIL_i in the same cycle as any restart is discarded, with no retry counted and no extra toggle.
- CIC_FAIL_i is evaluated only in RUN. Fail levels during HOLD/SETTLE are ignored.
- RETRY_o = min(retry, 3). The internal retry counter is wide enough for MAX_RETRY and never wraps.
- MAX_RETRY=0: the first failure goes straight to LOCKOUT, and REGION_o does not toggle.

## Timing
- Event sampled at edge n: state, REGION_o and outputs update at edge n (visible in cycle n+1). There is no combinational path from any input to any output.
- Reset-to-run: SYS_RESET_o=1 for exactly RESET_HOLD+CIC_SETTLE cycles after RST_i deasserts. CIC_EN_o and SYS_RESET_o change on the same edge.
- Fail-to-retry: one cycle from CIC_FAIL_i sampled high to SYS_RESET_o=1 and CIC_EN_o=0, with REGION_o toggling on that same edge.
- REGION_o never changes while CIC_EN_o=1 except on the edge that also drops CIC_EN_o.
- RST_i asserted mid-sequence: the next edge produces the reset values, and the sequence restarts from full RESET_HOLD.

## Test plan
Unless noted, the bench uses RESET_HOLD=4, CIC_SETTLE=8, MAX_RETRY=2, DEFAULT_REGION=0.
- Release RST_i, CIC_FAIL_i=0 → SYS_RESET_o=1 for exactly 12 cycles, then SYS_RESET_o=0, CIC_EN_o=1, REGION_o=0, RETRY_o=0.
- In RUN, pulse CIC_FAIL_i for 1 cycle → next cycle REGION_o=1, RETRY_o=1, CIC_EN_o=0. After 12 cycles the block is back in RUN.
- Assert CIC_FAIL_i on each RUN entry three times → REGION_o sequence 0→1→0. On the third failure FAIL_o=1, SYS_RESET_o=1 held for 100+ cycles, RETRY_o=2.
- From LOCKOUT, pulse IGR_REGION_REQ_i together with IGR_RST_REQ_i → FAIL_o=0, RETRY_o=0, a single REGION_o toggle, RUN after 12 cycles.
- In SETTLE, assert RESET_BTN_i for 5 cycles while CIC_FAIL_i=1 → no retry counted. RUN is reached exactly 12 cycles after the button is released.
- With MAX_RETRY=0: one CIC_FAIL_i in RUN → LOCKOUT next cycle and REGION_o unchanged. Asserting RST_i mid-HOLD restores all reset values.
